hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Execute-stage sequencer for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage.
- Runs a pipelined multiply or a 32-iteration restoring divide.
- Stalls the pipeline while busy.
- Issues exactly one write (we/select/data) to the HI/LO register per committed op.
- Sits between the E-stage decode/ALU operands and the HI/LO register; drives that register's we, hilo_selectE and hilo_in.

Parameters:
MUL_LAT, 2, multiply latency in cycles from accept to write (legal 1..4)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
op_valid  input  1  E-stage op present
op  input  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others ignored
src_a  input  32  rs operand / dividend / MT source
src_b  input  32  rt operand / divisor
flush  input  1  cancel E-stage op (exception/eret)
stall  output  1  hold pipeline
hilo_we  output  1  write strobe to HI/LO register
hilo_select  output  2  00 write both, 11 HI only, 10 LO only
hilo_wdata  output  64  {hi,lo} write data

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (rst=0, async): state=IDLE; stall=0, hilo_we=0, hilo_select=00, hilo_wdata=0; counters and partial results cleared.
- IDLE, MTHI/MTLO valid, no flush:
  - Combinational write in the same cycle: hilo_we=1, stall=0.
  - MTHI: select=11, wdata={src_a, 32'h0}. MTLO: select=10, wdata={32'h0, src_a}.
  - State stays IDLE.
- IDLE, MULT/MULTU/DIV/DIVU valid, no flush:
  - Accept cycle (cycle 0): operands latched, stall=1 combinationally.
  - Multiply goes to MUL; divide goes to DIV.
- MUL:
  - 64-bit product held in a MUL_LAT-deep register chain; signed for MULT, unsigned for MULTU.
  - Counter runs cycles 1..MUL_LAT-1, stall=1, then DONE.
  - MUL_LAT=1: go directly from accept to DONE.
- DIV:
  - Operate on magnitudes (|src| for DIV, raw for DIVU).
  - One restoring quotient bit per cycle for 32 cycles (cycles 1..32), stall=1, then DONE.
  - Sign correction for DIV: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
  - Divisor 0 (both DIV and DIVU): lo=0xFFFFFFFF, hi=src_a, sign correction skipped, full 32 cycles.
- DONE (one cycle):
  - hilo_we=1, select=00, wdata={hi=remainder|product[63:32], lo=quotient|product[31:0]}.
  - stall=0 so the op retires; then IDLE.
  - op_valid is still high in this cycle for the same op and must NOT be re-accepted.
- Latency from accept to write: multiply MUL_LAT cycles; divide 33 cycles.
- A back-to-back op is accepted the cycle after DONE.
- flush=1 in any state:
  - Forces IDLE at the next edge; stall=0 and hilo_we=0 in that cycle.
  - In IDLE, flush suppresses both the accept and any MT write.
  - The partial result is discarded and no write ever issues for the cancelled op.
- op_valid=0 or an unknown op in IDLE: no action.
- Operands are sampled only on accept; later changes to src_a/src_b are ignored.

Optional Feature:
DIV_ZERO_FAST_EN
- Defined: divide with src_b==0 goes from accept straight to DONE, writing the same divisor-0 result at cycle 1.
- Undefined: divisor 0 takes the full 33-cycle latency.

Test Plan:
1. MULT src_a=0xFFFFFFFE (-2), src_b=3, MUL_LAT=2 -> stall=1 for cycles 0-1; hilo_we=1 at cycle 2 with wdata=0xFFFFFFFF_FFFFFFFA, select=00; no second write.
2. DIVU 100/7 -> stall for cycles 0-32; cycle 33 hilo_we=1, wdata={hi=2, lo=14}. DIV -7/2 -> {hi=0xFFFFFFFF, lo=0xFFFFFFFD}.
3. DIV 0x80000000/0xFFFFFFFF -> {hi=0, lo=0x80000000}. DIVU 5/0 -> {hi=5, lo=0xFFFFFFFF}: at cycle 33 without the macro, cycle 1 with DIV_ZERO_FAST_EN.
4. MTHI 0x1234 -> same cycle hilo_we=1, select=11, wdata[63:32]=0x1234, stall=0. MTLO 0xABCD -> select=10, wdata[31:0]=0xABCD.
5. DIV started, flush=1 at cycle 10 -> IDLE next edge, stall=0, hilo_we never asserted; MULTU 0xFFFFFFFF*0xFFFFFFFF then completes normally with 0xFFFFFFFE_00000001.
6. rst=0 asserted mid-DIV (between clock edges) -> all outputs 0 immediately; after release, op_valid=0 keeps IDLE with no write.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: execute-stage sequencer for the HI/LO register pair.
// Runs MULT/MULTU through a MUL_LAT-deep product pipeline and DIV/DIVU as a
// 32-step restoring divide, holding the pipeline (stall_o) while busy and
// issuing exactly one HI/LO write per committed op. MTHI/MTLO write in the
// same cycle without stalling.
// Optional build macro: DIV_ZERO_FAST_EN -- a divide by zero skips the
// 32 iteration cycles and writes its fixed result one cycle after accept.
// Handshake: an op is presented with op_valid_i and held until stall_o is low
// in a cycle; that cycle retires it. flush_i cancels whatever is in flight.
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [1:0]  hilo_select_o,
    output logic [63:0] hilo_wdata_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd32;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;

    // Operands and divide working registers, captured on accept.
    logic        is_div_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        div_zero_q;
    logic [31:0] a_hold_q;
    logic [31:0] dvs_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [63:0] prod_q [MUL_LAT];

    // Decode of the presented op.
    logic        is_mul_op, is_div_op, is_long_op, accept;
    logic        signed_op;
    logic [31:0] abs_a, abs_b;
    logic [63:0] ext_a, ext_b, prod_now;

    assign is_mul_op  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_div_op  = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign is_long_op = is_mul_op || is_div_op;
    assign accept     = rst_ni && (state_q == S_IDLE) && op_valid_i && !flush_i && is_long_op;
    assign signed_op  = (op_i == OP_MULT) || (op_i == OP_DIV);

    // Divides run on magnitudes; signs are restored when the result is written.
    assign abs_a = (signed_op && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
    assign abs_b = (signed_op && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

    // Sign/zero extension to 64 bits makes the low 64 product bits exact.
    assign ext_a    = signed_op ? {{32{src_a_i[31]}}, src_a_i} : {32'h0, src_a_i};
    assign ext_b    = signed_op ? {{32{src_b_i[31]}}, src_b_i} : {32'h0, src_b_i};
    assign prod_now = ext_a * ext_b;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] rem_shift, rem_diff;
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};

    // Sign-corrected divide result as seen in DONE.
    logic [31:0] quo_fix, rem_fix;
    assign quo_fix = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = r_neg_q ? (~rem_q + 32'd1) : rem_q;

    // State and iteration counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = 6'd1;
                    if (is_mul_op) begin
                        state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
                    end else begin
                        state_d = S_DIV;
`ifdef DIV_ZERO_FAST_EN
                        if (src_b_i == 32'h0) state_d = S_DONE;
`endif
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) state_d = S_DONE;
                else                   cnt_d   = cnt_q + 6'd1;
            end
            S_DIV: begin
                if (cnt_q == DIV_LAST) state_d = S_DONE;
                else                   cnt_d   = cnt_q + 6'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Operand capture on accept and one quotient bit per DIV cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_div_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            a_hold_q   <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
        end else if (accept) begin
            is_div_q   <= is_div_op;
            q_neg_q    <= signed_op && (src_a_i[31] ^ src_b_i[31]);
            r_neg_q    <= signed_op && src_a_i[31];
            div_zero_q <= (src_b_i == 32'h0);
            a_hold_q   <= src_a_i;
            dvs_q      <= abs_b;
            quo_q      <= abs_a;
            rem_q      <= '0;
        end else if (state_q == S_DIV) begin
            if (!rem_diff[32]) begin
                rem_q <= rem_diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= rem_shift[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    // Product pipeline: loaded at accept, reaches the last stage in DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
        end else begin
            prod_q[0] <= (accept && is_mul_op) ? prod_now : '0;
            for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    // Outputs: stall while a long op is in flight, single write in DONE or for MT*.
    always_comb begin
        stall_o       = 1'b0;
        hilo_we_o     = 1'b0;
        hilo_select_o = 2'b00;
        hilo_wdata_o  = 64'h0;
        if (rst_ni && !flush_i) begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid_i) begin
                        if (op_i == OP_MTHI) begin
                            hilo_we_o     = 1'b1;
                            hilo_select_o = 2'b11;
                            hilo_wdata_o  = {src_a_i, 32'h0};
                        end else if (op_i == OP_MTLO) begin
                            hilo_we_o     = 1'b1;
                            hilo_select_o = 2'b10;
                            hilo_wdata_o  = {32'h0, src_a_i};
                        end else if (is_long_op) begin
                            stall_o = 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: stall_o = 1'b1;
                S_DONE: begin
                    hilo_we_o     = 1'b1;
                    hilo_select_o = 2'b00;
                    if (!is_div_q)      hilo_wdata_o = prod_q[MUL_LAT-1];
                    else if (div_zero_q) hilo_wdata_o = {a_hold_q, 32'hFFFF_FFFF};
                    else                hilo_wdata_o = {rem_fix, quo_fix};
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed op sequence with a
// write scoreboard ({select, wdata} queue) checked on every hilo_we_o.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_LAT = 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall, hilo_we;
  logic [1:0]  hilo_select, state;
  logic [63:0] hilo_wdata;

  int passed = 0;
  int total  = 0;
  logic [65:0] exp_q[$];

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
    .stall_o(stall), .hilo_we_o(hilo_we), .hilo_select_o(hilo_select),
    .hilo_wdata_o(hilo_wdata), .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && hilo_we === 1'b1) begin
      total++;
      assert (exp_q.size() > 0) passed++;
      else $error("FAIL spurious_write: observed sel=%b data=%h expected no write", hilo_select, hilo_wdata);
      if (exp_q.size() > 0) check("write_data", {hilo_select, hilo_wdata}, exp_q.pop_front());
    end
  end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int ia, ib, q, r;
    logic [63:0] ua, ub;
    case (o)
      OP_MULT: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      OP_MULTU: begin
        ua = {32'h0, a}; ub = {32'h0, b};
        return ua * ub;
      end
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = int'(a); ib = int'(b);
        q = ia / ib; r = ia % ib;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // driver: present a long op, expect stall until cycle lat, one write at lat
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string tag);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    exp_q.push_back({2'b00, exp});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) check({tag, "_busy"}, {64'h0, stall, hilo_we}, 66'b10);
      else         check({tag, "_done"}, {64'h0, stall, hilo_we}, 66'b01);
      @(posedge clk); #1;
      if (k == 0) begin
        src_a = $urandom; src_b = $urandom;
      end
    end
    op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    check({tag, "_after"}, {62'h0, stall, hilo_we, state}, 66'h0);
    @(posedge clk); #1;
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] a, input string tag);
    op_valid = 1'b1; op = o; src_a = a;
    if (o == OP_MTHI) exp_q.push_back({2'b11, a, 32'h0});
    else              exp_q.push_back({2'b10, 32'h0, a});
    @(negedge clk);
    check({tag, "_same_cycle"}, {64'h0, stall, hilo_we}, 66'b01);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    check({tag, "_state"}, {64'h0, state}, 66'h0);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle(input logic [2:0] o, input logic fl, input string tag);
    op_valid = 1'b1; op = o; flush = fl; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    check({tag, "_quiet"}, {64'h0, stall, hilo_we}, 66'b00);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0; flush = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {64'h0, state}, 66'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; op_valid = 1'b1; op = OP_MTHI; src_a = 32'h1234; src_b = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {62'h0, stall, hilo_we, hilo_select}, 66'h0);
    check("reset_wdata", {2'b00, hilo_wdata}, 66'h0);
    check("reset_state", {64'h0, state}, 66'h0);
    op_valid = 1'b0; op = 3'd0; src_a = 32'h0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, MUL_LAT, "mult_neg");
    run_op(OP_DIVU,  32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, "div_ovf");
    run_op(OP_DIVU,  32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DZ_LAT, "divu_zero");
    run_op(OP_DIV,   32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, DZ_LAT, "div_zero");
    run_op(OP_DIV,   32'h7FFF_FFFF, 32'hFFFF_FFFD, {32'd1, 32'hD555_5556}, 33, "div_pos_neg");

    run_mt(OP_MTHI, 32'h0000_1234, "mthi");
    run_mt(OP_MTLO, 32'h0000_ABCD, "mtlo");

    // flush a divide at cycle 10
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("flush_div_busy", {64'h0, stall, hilo_we}, 66'b10);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle", {64'h0, stall, hilo_we}, 66'b00);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 3'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) check("flush_idle", {62'h0, stall, hilo_we, state}, 66'h0);
      @(posedge clk); #1;
    end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, "multu_max");

    // flush and unknown ops in IDLE do nothing
    idle_cycle(OP_MTHI, 1'b1, "flush_mthi");
    idle_cycle(OP_DIV,  1'b1, "flush_accept");
    idle_cycle(3'd0,    1'b0, "op_000");
    idle_cycle(3'd7,    1'b0, "op_111");

    // random long ops against the arithmetic model
    for (int n = 0; n < 6; n++) begin
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = (n == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), (ro <= OP_MULTU) ? MUL_LAT : 33, "random_op");
    end

    // asynchronous reset in the middle of a divide
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {62'h0, stall, hilo_we, hilo_select}, 66'h0);
    check("midrst_wdata", {2'b00, hilo_wdata}, 66'h0);
    check("midrst_state", {64'h0, state}, 66'h0);
    op_valid = 1'b0; op = 3'd0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 3) check("post_rst_idle", {62'h0, stall, hilo_we, state}, 66'h0);
    end

    total++;
    assert (exp_q.size() == 0) passed++;
    else $error("FAIL pending_writes: observed %0d outstanding expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
